// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment definitions: segment bit order, glyph
//            constants, slot-state encoding and the BCD decode function.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Segment vector, active-high. Bit order: bit0 = a, bit1 = b, ... bit6 = g.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_A = 7'h01;
  localparam seg_t SEG_B = 7'h02;
  localparam seg_t SEG_C = 7'h04;
  localparam seg_t SEG_D = 7'h08;
  localparam seg_t SEG_E = 7'h10;
  localparam seg_t SEG_F = 7'h20;
  localparam seg_t SEG_G = 7'h40;

  localparam seg_t SEG_0    = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
  localparam seg_t SEG_1    = SEG_B | SEG_C;
  localparam seg_t SEG_2    = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
  localparam seg_t SEG_3    = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
  localparam seg_t SEG_4    = SEG_B | SEG_C | SEG_F | SEG_G;
  localparam seg_t SEG_5    = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
  localparam seg_t SEG_6    = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
  localparam seg_t SEG_7    = SEG_A | SEG_B | SEG_C;
  localparam seg_t SEG_8    = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
  localparam seg_t SEG_9    = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
  localparam seg_t SEG_DASH = SEG_G;

  // Phase within one digit slot: blank guard first, then the digit is lit.
  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

  // Non-decimal codes render as a dash so a corrupted counter is visible.
  function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
    seg_t seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver_if
// Purpose  : Bundle between the BCD counter side (master) and the scanned
//            7-segment display driver (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   blink_i;
  logic                    blink_tick_i;
  logic                    lz_blank_i;
  logic [6:0]              seg_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   dig_o;
  logic                    frame_o;

  modport master (
    output digits_i, dp_i, blink_i, blink_tick_i, lz_blank_i,
    input  seg_o, dp_o, dig_o, frame_o
  );

  modport slave (
    input  digits_i, dp_i, blink_i, blink_tick_i, lz_blank_i,
    output seg_o, dp_o, dig_o, frame_o
  );

endinterface
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational BCD to 7-segment decoder (active-high segments).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  // Pure lookup through the shared decode function.
  always_comb begin
    seg_o = bcd_to_seg(bcd_i);
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed common-cathode 7-segment driver with guard
//            blanking, once-per-frame input snapshot, leading-zero
//            suppression, decimal points and per-digit blinking.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  seg7_scan_driver_if.slave bus
);

  localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int                IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
  logic                    snap_lz_q, snap_lz_d;
  logic                    snap_phase_q, snap_phase_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q, frame_d;

  logic                    snap_load;
  slot_state_e             slot_state;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    blank;
  logic [3:0]              cur_bcd;
  seg_t                    cur_seg;

  bcd_to_seg7 u_dec (
    .bcd_i (cur_bcd),
    .seg_o (cur_seg)
  );

  // Slot counter, digit index, blink phase and frame snapshot next-state.
  always_comb begin
    snap_load = (cnt_q == '0) && (idx_q == '0);
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (cnt_q == CNT_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    // The snapshot takes the phase as it stands, so a coincident tick lands next frame.
    phase_d       = phase_q ^ bus.blink_tick_i;
    snap_digits_d = snap_load ? bus.digits_i   : snap_digits_q;
    snap_dp_d     = snap_load ? bus.dp_i       : snap_dp_q;
    snap_blink_d  = snap_load ? bus.blink_i    : snap_blink_q;
    snap_lz_d     = snap_load ? bus.lz_blank_i : snap_lz_q;
    snap_phase_d  = snap_load ? phase_q        : snap_phase_q;
    frame_d       = snap_load;
  end

  // Leading-zero mask: digit d is suppressed when it and every digit above it is zero.
  always_comb begin : b_lz
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      all_zero   = all_zero & (snap_digits_q[4*d +: 4] == 4'd0);
      lz_mask[d] = snap_lz_q & all_zero & (d != 0);
    end
  end

  // Slot phase decode and next display outputs for the current digit.
  always_comb begin
    slot_state = (cnt_q < CNT_GUARD) ? ST_GUARD : ST_DRIVE;
    cur_bcd    = snap_digits_q[{idx_q, 2'b00} +: 4];
    blank      = (snap_blink_q[idx_q] & snap_phase_q) | lz_mask[idx_q];
    seg_d      = '0;
    dp_d       = 1'b0;
    dig_d      = '0;
    if (slot_state == ST_DRIVE) begin
      dig_d[idx_q] = 1'b1;
      if (!blank) begin
        seg_d = cur_seg;
        dp_d  = snap_dp_q[idx_q];
      end
    end
  end

  // All state and outputs registered; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      phase_q       <= 1'b0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blink_q  <= '0;
      snap_lz_q     <= 1'b0;
      snap_phase_q  <= 1'b0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      dig_q         <= '0;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_blink_q  <= snap_blink_d;
      snap_lz_q     <= snap_lz_d;
      snap_phase_q  <= snap_phase_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_q         <= dig_d;
      frame_q       <= frame_d;
    end
  end

  assign bus.seg_o   = seg_q;
  assign bus.dp_o    = dp_q;
  assign bus.dig_o   = dig_q;
  assign bus.frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver (4 digits, 8-cycle
//            slots, 2-cycle guard) with a cycle-level reference scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] dig;
    logic          frame;
  } out_t;

  out_t sb[$];
  out_t exp_o;
  out_t got_o;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: m_k is the index of the current cycle since reset release.
  int          m_k;
  logic        m_phase;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic [3:0]  m_blink;
  logic        m_lz;
  logic        m_sphase;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Predict the outputs of the next cycle, advance one clock, pop the prediction.
  task automatic step();
    out_t e;
    int   pos;
    int   slot;
    logic allz;
    logic blank;
    e = '0;
    if (rst) begin
      m_k = 0; m_phase = 1'b0; m_digits = '0; m_dp = '0;
      m_blink = '0; m_lz = 1'b0; m_sphase = 1'b0;
    end else begin
      pos     = m_k % SD;
      slot    = (m_k / SD) % ND;
      e.frame = ((m_k % (ND * SD)) == 0);
      if (pos >= GC) begin
        e.dig[slot] = 1'b1;
        allz = 1'b1;
        for (int d = slot; d < ND; d++) if (m_digits[4*d +: 4] != 4'd0) allz = 1'b0;
        blank = (m_blink[slot] && m_sphase) || (m_lz && slot != 0 && allz);
        if (!blank) begin
          e.seg = ref_seg(m_digits[4*slot +: 4]);
          e.dp  = m_dp[slot];
        end
      end
      if (e.frame) begin
        m_digits = bus.digits_i; m_dp = bus.dp_i; m_blink = bus.blink_i;
        m_lz = bus.lz_blank_i; m_sphase = m_phase;
      end
      m_phase = m_phase ^ bus.blink_tick_i;
      m_k++;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got_o = {bus.seg_o, bus.dp_o, bus.dig_o, bus.frame_o};
    exp_o = sb.pop_front();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_inputs(input logic [15:0] dg, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lz);
    bus.digits_i = dg; bus.dp_i = dp; bus.blink_i = bl;
    bus.lz_blank_i = lz; bus.blink_tick_i = 1'b0;
  endtask

  task automatic test_reset();
    set_inputs(16'h1234, 4'hF, 4'h0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (got_o !== exp_o || got_o !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h exp=%h", i, got_o, exp_o);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    set_inputs(16'h1234, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      step();
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL scan_model k=%0d got=%h exp=%h", m_k, got_o, exp_o);
      end
      checks++;
      if (bus.frame_o !== (m_k == 1 || m_k == 33)) begin
        failures++;
        $display("FAIL scan_frame k=%0d got=%b", m_k, bus.frame_o);
      end
      if (m_k == 3 || m_k == 8) begin
        checks++;
        if (bus.dig_o !== 4'b0001 || bus.seg_o !== 7'h66) begin
          failures++;
          $display("FAIL scan_digit0 k=%0d got dig=%b seg=%h exp dig=0001 seg=66", m_k, bus.dig_o, bus.seg_o);
        end
      end
      if (m_k == 9 || m_k == 10) begin
        checks++;
        if (bus.dig_o !== 4'b0000 || bus.seg_o !== 7'h00 || bus.dp_o !== 1'b0) begin
          failures++;
          $display("FAIL scan_guard k=%0d got dig=%b seg=%h exp 0", m_k, bus.dig_o, bus.seg_o);
        end
      end
      if (m_k == 11 || m_k == 16) begin
        checks++;
        if (bus.dig_o !== 4'b0010 || bus.seg_o !== 7'h4F) begin
          failures++;
          $display("FAIL scan_digit1 k=%0d got dig=%b seg=%h exp dig=0010 seg=4f", m_k, bus.dig_o, bus.seg_o);
        end
      end
    end
  endtask

  task automatic test_lz();
    do_reset();
    set_inputs(16'h0007, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (m_k == 20) bus.digits_i = 16'h0000;
      step();
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL lz_model k=%0d got=%h exp=%h", m_k, got_o, exp_o);
      end
      if (m_k == 5 || m_k == 14 || m_k == 30 || m_k == 37) begin
        checks++;
        if (bus.seg_o !== (m_k == 5 ? 7'h07 : (m_k == 37 ? 7'h3F : 7'h00)) ||
            bus.dig_o !== (m_k == 14 ? 4'b0010 : (m_k == 30 ? 4'b1000 : 4'b0001))) begin
          failures++;
          $display("FAIL lz_digit k=%0d got dig=%b seg=%h", m_k, bus.dig_o, bus.seg_o);
        end
      end
    end
  endtask

  task automatic test_tear();
    do_reset();
    set_inputs(16'h1234, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 45; i++) begin
      if (m_k == 12) bus.digits_i = 16'h5678;
      step();
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL tear_model k=%0d got=%h exp=%h", m_k, got_o, exp_o);
      end
      if (m_k == 14 || m_k == 30 || m_k == 38) begin
        checks++;
        if (bus.seg_o !== (m_k == 14 ? 7'h4F : (m_k == 30 ? 7'h06 : 7'h7F))) begin
          failures++;
          $display("FAIL tear_snapshot k=%0d got seg=%h", m_k, bus.seg_o);
        end
      end
    end
  endtask

  task automatic test_blink();
    do_reset();
    set_inputs(16'h1234, 4'h0, 4'b1100, 1'b0);
    for (int i = 0; i < 100; i++) begin
      bus.blink_tick_i = (m_k == 5 || m_k == 40);
      step();
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL blink_model k=%0d got=%h exp=%h", m_k, got_o, exp_o);
      end
      if (m_k == 22 || m_k == 54 || m_k == 62 || m_k == 86) begin
        checks++;
        if (bus.dig_o !== (m_k == 62 ? 4'b1000 : 4'b0100) ||
            bus.seg_o !== ((m_k == 22 || m_k == 86) ? 7'h5B : 7'h00)) begin
          failures++;
          $display("FAIL blink_digit k=%0d got dig=%b seg=%h", m_k, bus.dig_o, bus.seg_o);
        end
      end
    end
    bus.blink_tick_i = 1'b0;
  endtask

  task automatic test_dash_dp();
    do_reset();
    set_inputs(16'h12B4, 4'b0010, 4'h0, 1'b0);
    for (int i = 0; i < 34; i++) begin
      step();
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL dash_model k=%0d got=%h exp=%h", m_k, got_o, exp_o);
      end
      if (m_k == 5 || m_k == 13) begin
        checks++;
        if (bus.seg_o !== (m_k == 13 ? 7'h40 : 7'h66) || bus.dp_o !== (m_k == 13)) begin
          failures++;
          $display("FAIL dash_dp k=%0d got seg=%h dp=%b", m_k, bus.seg_o, bus.dp_o);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_inputs(16'h1234, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL midrst_model k=%0d got=%h exp=%h", m_k, got_o, exp_o);
      end
    end
    checks++;
    if (bus.dig_o !== 4'b0100) begin
      failures++;
      $display("FAIL midrst_driving got dig=%b exp 0100", bus.dig_o);
    end
    rst = 1'b1;
    step();
    checks++;
    if (got_o !== exp_o || got_o !== '0) begin
      failures++;
      $display("FAIL midrst_zero got=%h exp=0", got_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL midrst_restart k=%0d got=%h exp=%h", m_k, got_o, exp_o);
      end
      if (m_k == 1 || m_k == 3) begin
        checks++;
        if ((m_k == 1 && bus.frame_o !== 1'b1) ||
            (m_k == 3 && (bus.dig_o !== 4'b0001 || bus.seg_o !== 7'h66))) begin
          failures++;
          $display("FAIL midrst_resume k=%0d got frame=%b dig=%b seg=%h", m_k, bus.frame_o, bus.dig_o, bus.seg_o);
        end
      end
    end
  endtask

  initial begin
    set_inputs(16'h0000, 4'h0, 4'h0, 1'b0);
    test_reset();
    test_scan();
    test_lz();
    test_tear();
    test_blink();
    test_dash_dp();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
